// File: rtl/hawk_pkg.sv
// HAWK beacon shared definitions.
// Phase encodings, default timing and a width sanity helper.
package hawk_pkg;

  typedef enum logic [2:0] {
    ST_DARK    = 3'd0,
    ST_FLASH_Y = 3'd1,
    ST_SOLID_Y = 3'd2,
    ST_SOLID_R = 3'd3,
    ST_WIGWAG  = 3'd4,
    ST_RECOVER = 3'd5
  } hawk_state_e;

  localparam int DEF_TICK_DIV  = 5;
  localparam int DEF_FLASH_Y_T = 4;
  localparam int DEF_SOLID_Y_T = 3;
  localparam int DEF_WALK_T    = 6;
  localparam int DEF_CLEAR_T   = 5;
  localparam int DEF_RECOVER_T = 8;
  localparam int DEF_CW        = 4;

  function automatic bit cw_fits(
    input int cw,
    input int fy,
    input int sy,
    input int wk,
    input int cl,
    input int rc
  );
    int m;
    m = fy;
    if (sy > m) m = sy;
    if (wk > m) m = wk;
    if (cl > m) m = cl;
    if (rc > m) m = rc;
    return (m - 1) < (1 << cw);
  endfunction

endpackage

// File: rtl/hawk_phase_sequencer_if.sv
// Button/standby inputs and lamp/status outputs of the sequencer.
// slave is the sequencer side, master the board side.
interface hawk_phase_sequencer_if #(
  parameter int CW = 4
);
  logic          YP;
  logic          NS;
  logic [2:0]    state;
  logic [CW-1:0] count;
  logic          YL;
  logic          RL_L;
  logic          RL_R;
  logic          W;
  logic          DNW;
  logic          busy;
  logic          req_pending;

  modport slave (
    input  YP, NS,
    output state, count, YL, RL_L, RL_R,
    output W, DNW, busy, req_pending
  );

  modport master (
    output YP, NS,
    input  state, count, YL, RL_L, RL_R,
    input  W, DNW, busy, req_pending
  );
endinterface

// File: rtl/hawk_tick_gen.sv
// Free-running prescaler producing the timing tick and
// the lamp flash bit, which toggles once per tick.
module hawk_tick_gen #(
  parameter int TICK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic flash
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          flash_q, flash_d;

  assign tick  = (pre_q == LAST);
  assign flash = flash_q;

  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    flash_d = flash_q ^ tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      flash_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      flash_q <= flash_d;
    end
  end
endmodule

// File: rtl/hawk_phase_sequencer.sv
// HAWK pedestrian beacon sequencer: request latch,
// tick-timed phase FSM and Moore lamp decode.
module hawk_phase_sequencer
  import hawk_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int FLASH_Y_T = DEF_FLASH_Y_T,
  parameter int SOLID_Y_T = DEF_SOLID_Y_T,
  parameter int WALK_T    = DEF_WALK_T,
  parameter int CLEAR_T   = DEF_CLEAR_T,
  parameter int RECOVER_T = DEF_RECOVER_T,
  parameter int CW        = DEF_CW
) (
  input  logic clk,
  input  logic rst,
  hawk_phase_sequencer_if.slave bus
);

  if (!cw_fits(CW, FLASH_Y_T, SOLID_Y_T,
               WALK_T, CLEAR_T, RECOVER_T)) begin : g_cw_bad
    $error("CW too narrow for phase durations");
  end

  logic tick, flash;

  hawk_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .flash (flash)
  );

  hawk_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_q, req_d;
  logic          yl, rl_l, rl_r, w, dnw;

  function automatic logic [CW-1:0] last_of(
    input hawk_state_e s
  );
    case (s)
      ST_FLASH_Y: return CW'(FLASH_Y_T - 1);
      ST_SOLID_Y: return CW'(SOLID_Y_T - 1);
      ST_SOLID_R: return CW'(WALK_T - 1);
      ST_WIGWAG:  return CW'(CLEAR_T - 1);
      ST_RECOVER: return CW'(RECOVER_T - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic hawk_state_e next_of(
    input hawk_state_e s
  );
    case (s)
      ST_FLASH_Y: return ST_SOLID_Y;
      ST_SOLID_Y: return ST_SOLID_R;
      ST_SOLID_R: return ST_WIGWAG;
      ST_WIGWAG:  return ST_RECOVER;
      default:    return ST_DARK;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_DARK: begin
        count_d = '0;
        if (tick && req_q && !bus.NS)
          state_d = ST_FLASH_Y;
      end
      ST_FLASH_Y, ST_SOLID_Y, ST_SOLID_R,
      ST_WIGWAG, ST_RECOVER: begin
        if (tick) begin
          if (count_q == last_of(state_q)) begin
            state_d = next_of(state_q);
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_DARK;
        count_d = '0;
      end
    endcase
  end

  // Walk entry consumes the request; later presses queue a new one.
  always_comb begin
    req_d = req_q | bus.YP;
    if (state_d == ST_SOLID_R && state_q != ST_SOLID_R)
      req_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DARK;
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    yl   = 1'b0;
    rl_l = 1'b0;
    rl_r = 1'b0;
    w    = 1'b0;
    dnw  = 1'b1;
    case (state_q)
      ST_FLASH_Y: yl = flash;
      ST_SOLID_Y: yl = 1'b1;
      ST_SOLID_R: begin
        rl_l = 1'b1;
        rl_r = 1'b1;
        w    = 1'b1;
        dnw  = 1'b0;
      end
      ST_WIGWAG: begin
        rl_l = flash;
        rl_r = ~flash;
        dnw  = flash;
      end
      default: ;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.count       = count_q;
  assign bus.YL          = yl;
  assign bus.RL_L        = rl_l;
  assign bus.RL_R        = rl_r;
  assign bus.W           = w;
  assign bus.DNW         = dnw;
  assign bus.busy        = (state_q != ST_DARK);
  assign bus.req_pending = req_q;

endmodule

// File: tb/tb_hawk_phase_sequencer.sv
// Directed plus random bench for hawk_phase_sequencer,
// checked against a tick-timeline reference model.
module tb_hawk_phase_sequencer;

  localparam int TD    = 5;
  localparam int P_FY  = 4;
  localparam int P_SY  = 3;
  localparam int P_WK  = 6;
  localparam int P_CL  = 5;
  localparam int P_RC  = 8;
  localparam int TOTAL = P_FY + P_SY + P_WK + P_CL + P_RC;

  logic clk;
  logic rst;

  hawk_phase_sequencer_if #(.CW(4)) bus ();

  hawk_phase_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: edges since reset, ticks since reset, and the
  // tick at which the current crossing began.
  int k      = 0;
  int ticks  = 0;
  int seq_t0 = 0;
  bit in_seq = 0;
  bit req    = 0;
  bit ns_v   = 0;

  int         cross_cnt = 0;
  logic [2:0] prev_st   = 3'd0;

  function automatic int m_elapsed();
    return ticks - seq_t0;
  endfunction

  function automatic int m_phase();
    int e;
    if (!in_seq) return 0;
    e = m_elapsed();
    if (e < P_FY) return 1;
    if (e < P_FY + P_SY) return 2;
    if (e < P_FY + P_SY + P_WK) return 3;
    if (e < P_FY + P_SY + P_WK + P_CL) return 4;
    return 5;
  endfunction

  function automatic int m_count();
    int e;
    if (!in_seq) return 0;
    e = m_elapsed();
    if (e < P_FY) return e;
    e -= P_FY;
    if (e < P_SY) return e;
    e -= P_SY;
    if (e < P_WK) return e;
    e -= P_WK;
    if (e < P_CL) return e;
    return e - P_CL;
  endfunction

  task automatic model_edge(input bit r, input bit y, input bit n);
    int old_p;
    bit tk;
    if (r) begin
      k      = 0;
      ticks  = 0;
      in_seq = 0;
      req    = 0;
      return;
    end
    old_p = m_phase();
    tk = (k % TD) == (TD - 1);
    k++;
    if (tk) begin
      ticks++;
      if (in_seq && m_elapsed() >= TOTAL)
        in_seq = 0;
      else if (!in_seq && req && !n) begin
        in_seq = 1;
        seq_t0 = ticks;
      end
    end
    if (m_phase() == 3 && old_p != 3) req = 0;
    else req = req | y;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  p;
    bit  fl;
    p  = m_phase();
    fl = ticks[0];
    chk("state", 32'(bus.state), 32'(p));
    chk("count", 32'(bus.count), 32'(m_count()));
    chk("YL", 32'(bus.YL),
        32'((p == 1) ? fl : (p == 2)));
    chk("RL_L", 32'(bus.RL_L),
        32'((p == 3) || (p == 4 && fl)));
    chk("RL_R", 32'(bus.RL_R),
        32'((p == 3) || (p == 4 && !fl)));
    chk("W", 32'(bus.W), 32'(p == 3));
    chk("DNW", 32'(bus.DNW),
        32'((p == 4) ? fl : (p != 3)));
    chk("busy", 32'(bus.busy), 32'(p != 0));
    chk("req_pending", 32'(bus.req_pending), 32'(req));
    chk("w_dnw_excl", 32'(bus.W & bus.DNW), 32'd0);
  endtask

  task automatic step(input bit r, input bit y, input bit n);
    rst    = r;
    bus.YP = y;
    bus.NS = n;
    @(posedge clk);
    model_edge(r, y, n);
    @(negedge clk);
    if (bus.state == 3'd1 && prev_st != 3'd1) cross_cnt++;
    prev_st = bus.state;
    check_all();
  endtask

  task automatic run_until(input int p, input int limit,
                           output int n);
    n = 0;
    while (m_phase() != p && n < limit) begin
      step(1'b0, 1'b0, ns_v);
      n++;
    end
    chk($sformatf("reach_phase_%0d", p),
        32'(bus.state), 32'(p));
  endtask

  initial begin
    int n;
    bit r, y;
    rst    = 1'b1;
    bus.YP = 1'b0;
    bus.NS = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);

    // single press and exact phase lengths
    cross_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    run_until(1, 2 * TD, n);
    chk("press_latency_le_tick", 32'(n <= TD), 32'd1);
    run_until(2, 200, n);
    chk("flash_y_len", 32'(n), 32'(P_FY * TD));
    run_until(3, 200, n);
    chk("solid_y_len", 32'(n), 32'(P_SY * TD));
    run_until(4, 200, n);
    chk("walk_len", 32'(n), 32'(P_WK * TD));
    run_until(5, 200, n);
    chk("clear_len", 32'(n), 32'(P_CL * TD));
    run_until(0, 200, n);
    chk("recover_len", 32'(n), 32'(P_RC * TD));
    chk("single_crossings", 32'(cross_cnt), 32'd1);

    // second press during SOLID_Y merges
    cross_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    run_until(2, 200, n);
    step(1'b0, 1'b1, 1'b0);
    run_until(0, 300, n);
    repeat (30) step(1'b0, 1'b0, 1'b0);
    chk("merge_one_crossing", 32'(cross_cnt), 32'd1);

    // press during WIGWAG queues the next crossing
    cross_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    run_until(4, 300, n);
    step(1'b0, 1'b1, 1'b0);
    run_until(0, 300, n);
    chk("queued_req_held", 32'(bus.req_pending), 32'd1);
    run_until(1, 3 * TD, n);
    chk("requeue_latency", 32'(n), 32'(TD));
    run_until(0, 300, n);
    chk("queue_two_crossings", 32'(cross_cnt), 32'd2);

    // standby blocks exit from DARK only
    ns_v = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    chk("standby_dark", 32'(bus.state), 32'd0);
    ns_v = 1'b0;
    run_until(1, 3 * TD, n);
    chk("standby_release", 32'(n <= TD), 32'd1);
    run_until(3, 300, n);
    ns_v = 1'b1;
    run_until(0, 300, n);
    ns_v = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // reset mid-walk, then reset together with a press
    step(1'b0, 1'b1, 1'b0);
    run_until(3, 300, n);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_walk_W", 32'(bus.W), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_wins_req", 32'(bus.req_pending), 32'd0);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      y = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) ns_v = !ns_v;
      step(r, y, ns_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hawk_phase_sequencer.md
# hawk_phase_sequencer

Parameterised sequencer for a HAWK pedestrian hybrid beacon. It latches pedestrian requests and steps the beacon through dark, flashing yellow, solid yellow, solid red with walk, and wig-wag red with flashing don't-walk. It then enforces a minimum vehicle-recovery interval before the next crossing. It sits between the push-button/standby inputs and the lamp drivers, and replaces ad-hoc count/clear/increment control with one tick-timed controller.

## Interface
- TICK_DIV, 5: clk cycles per timing tick (≥2)
- FLASH_Y_T, 4: ticks in flashing yellow
- SOLID_Y_T, 3: ticks in solid yellow
- WALK_T, 6: ticks in solid red / walk
- CLEAR_T, 5: ticks in wig-wag / flashing DNW
- RECOVER_T, 8: minimum dark ticks after a crossing
- CW, 4: phase counter width; must hold every duration−1
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- YP  in  1  pedestrian push-button, level, already synchronised
- NS  in  1  night standby: high blocks new sequences
- state  out  3  current phase encoding
- count  out  CW  ticks elapsed in current phase
- YL  out  1  beacon yellow lamp
- RL_L  out  1  beacon left red lamp
- RL_R  out  1  beacon right red lamp
- W  out  1  walk indication
- DNW  out  1  don't-walk indication
- busy  out  1  high in any phase other than DARK
- req_pending  out  1  latched, unserved request

## Operation
- States and encodings:
  - DARK 0
  - FLASH_Y 1
  - SOLID_Y 2
  - SOLID_R 3
  - WIGWAG 4
  - RECOVER 5
  - Codes 6–7 are illegal and return to DARK on the next edge.
- Request latch:
  - YP=1 on any edge sets req_pending.
  - Entering SOLID_R clears it; YP high on that edge does not re-set it.
  - Presses during FLASH_Y/SOLID_Y merge into the current crossing.
  - Presses during SOLID_R (after entry), WIGWAG or RECOVER queue the next crossing.
- Transitions occur only on tick edges:
  - DARK→FLASH_Y when req_pending && !NS.
  - Any other phase X advances when count==X_T−1.
  - Order: FLASH_Y→SOLID_Y→SOLID_R→WIGWAG→RECOVER→DARK.
  - count clears to 0 on every transition, otherwise increments per tick.
  - In DARK, count holds 0.
- NS only gates DARK exit. A sequence already started always completes.
- Lamp decode (Moore, from registered state and flash bit):
  - DARK: all lamps 0, DNW=1.
  - FLASH_Y: YL=flash.
  - SOLID_Y: YL=1.
  - SOLID_R: RL_L=RL_R=1, W=1, DNW=0.
  - WIGWAG: RL_L=flash, RL_R=~flash, DNW=flash.
  - RECOVER: as DARK.
  - W and DNW are never both 1.
- Flash bit toggles every tick, free-running.

## Timing
- Prescaler counts 0..TICK_DIV−1. It is free-running and not reset by state changes.
- tick is high when prescaler==TICK_DIV−1. The first tick is on cycle TICK_DIV−1 after rst release (cycle 0 = first edge with rst low).
- Request latency:
  - YP→req_pending: 1 cycle.
  - req_pending→FLASH_Y: ≤TICK_DIV cycles (next tick edge).
- Phase X lasts exactly X_T·TICK_DIV cycles. Full sequence = (FLASH_Y_T+SOLID_Y_T+WALK_T+CLEAR_T+RECOVER_T)·TICK_DIV.
- A duration of 1 means one tick in the phase.
- Reset (any time, including mid-walk), on the next edge:
  - state=DARK, count=0, prescaler=0, flash=0, req_pending=0.
  - YL=RL_L=RL_R=W=0, DNW=1, busy=0.
- Simultaneous rst and YP: reset wins, so req_pending=0.

## Structure
- Package hawk_pkg holds:
  - the state encodings;
  - default duration constants;
  - a function checking that CW covers the maximum duration.
- Sub-module hawk_tick_gen holds the prescaler, tick strobe and flash toggle; parameter TICK_DIV.
- The top level holds the state register, phase counter, request latch and lamp decode.

## Test plan
- Reset idle: rst 3 cycles, then 20 idle cycles → state=0, DNW=1, all lamps 0, busy=0, flash toggles at cycles 4, 9, 14, 19.
- Single press: YP=1 at cycle 2 for 1 cycle → req_pending=1 at cycle 3, FLASH_Y at cycle 5 (after the cycle-4 tick edge). Then SOLID_Y at 25, SOLID_R/W=1 at 40, WIGWAG at 70, RECOVER at 95, DARK at 135.
- Merge and queue:
  - A second press during SOLID_Y → exactly one crossing.
  - A press during WIGWAG → req_pending stays 1, and FLASH_Y re-enters one tick after DARK.
- Standby: NS=1 and a press in DARK → stays DARK with req_pending=1. Dropping NS → FLASH_Y on the next tick. NS=1 raised mid-SOLID_R → sequence completes to DARK.
- Reset mid-walk: rst for 1 cycle during SOLID_R → next cycle state=0, W=0, DNW=1, req_pending=0, count=0.
- Wig-wag check: throughout WIGWAG, RL_L==~RL_R and DNW==RL_L on every cycle; W==0 always outside SOLID_R.
